// File: rtl/memory_stage.sv
// MEM pipeline stage: holds one instruction in M, runs byte/half/word loads and stores over a
// req/ack data-memory port, and presents the completed result to writeback in W.
module memory_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_RegWrite,
    input  logic        in_MemToReg,
    input  logic        in_RegDataSrc,
    input  logic        in_PCSrc,
    input  logic [4:0]  in_RegDest,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_value,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        out_RegWrite,
    output logic        out_MemToReg,
    output logic        out_RegDataSrc,
    output logic        out_PCSrc,
    output logic [4:0]  out_RegDest,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_mem_data,
    output logic        out_misaligned,
    output logic        out_bus_error,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;

    // M register: the instruction currently owning the stage
    logic        m_mem_write, m_mem_read, m_reg_write, m_mem_to_reg, m_reg_data_src, m_pc_src;
    logic [4:0]  m_reg_dest;
    logic [31:0] m_alu_result, m_rs2;
    logic [1:0]  m_size;
    logic        m_unsigned;

    logic        is_mem, misaligned, at_limit, timeout_hit, ack_ok;
    logic [31:0] load_data;

    always_comb begin
        is_mem     = m_mem_read | m_mem_write;
        misaligned = ((m_size == 2'b01) & m_alu_result[0]) |
                     (m_size[1] & (m_alu_result[1:0] != 2'b00));
        dmem_req   = is_mem & ~misaligned;
        dmem_we    = dmem_req & m_mem_write;
        dmem_addr  = {m_alu_result[31:2], 2'b00};
        // at_limit: this cycle is the TIMEOUT-th cycle req has been held
        if (state_q == StIdle) begin
            at_limit = (TIMEOUT == 1);
        end else begin
            at_limit = (wait_cnt_q == CW'(TIMEOUT - 1));
        end
        ack_ok      = dmem_req & dmem_ack;
        timeout_hit = dmem_req & ~dmem_ack & at_limit;
        stall       = dmem_req & ~dmem_ack & ~timeout_hit;
    end

    always_comb begin
        dmem_wdata = m_rs2;
        dmem_wstrb = 4'b0000;
        case (m_size)
            2'b00: begin
                dmem_wdata = {4{m_rs2[7:0]}};
                dmem_wstrb = 4'b0001 << m_alu_result[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{m_rs2[15:0]}};
                dmem_wstrb = m_alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dmem_wdata = m_rs2;
                dmem_wstrb = 4'b1111;
            end
        endcase
        if (!dmem_we) begin
            dmem_wstrb = 4'b0000;
        end
    end

    always_comb begin
        load_data = dmem_rdata;
        case (m_size)
            2'b00: begin
                load_data[7:0]  = dmem_rdata[8*m_alu_result[1:0] +: 8];
                load_data[31:8] = {24{~m_unsigned & load_data[7]}};
            end
            2'b01: begin
                load_data[15:0]  = m_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
                load_data[31:16] = {16{~m_unsigned & load_data[15]}};
            end
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = StIdle;
        wait_cnt_d = '0;
        if (stall) begin
            state_d    = StWait;
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_mem_write    <= 1'b0;
            m_mem_read     <= 1'b0;
            m_reg_write    <= 1'b0;
            m_mem_to_reg   <= 1'b0;
            m_reg_data_src <= 1'b0;
            m_pc_src       <= 1'b0;
            m_reg_dest     <= '0;
            m_alu_result   <= '0;
            m_rs2          <= '0;
            m_size         <= '0;
            m_unsigned     <= 1'b0;
            out_RegWrite   <= 1'b0;
            out_MemToReg   <= 1'b0;
            out_RegDataSrc <= 1'b0;
            out_PCSrc      <= 1'b0;
            out_RegDest    <= '0;
            out_alu_result <= '0;
            out_mem_data   <= '0;
            out_misaligned <= 1'b0;
            out_bus_error  <= 1'b0;
        end else if (!stall) begin
            m_mem_write    <= in_MemWrite;
            m_mem_read     <= in_MemRead;
            m_reg_write    <= in_RegWrite;
            m_mem_to_reg   <= in_MemToReg;
            m_reg_data_src <= in_RegDataSrc;
            m_pc_src       <= in_PCSrc;
            m_reg_dest     <= in_RegDest;
            m_alu_result   <= alu_result;
            m_rs2          <= rs2_value;
            m_size         <= mem_size;
            m_unsigned     <= mem_unsigned;
            // Faulted accesses must not write back
            out_RegWrite   <= m_reg_write & ~(is_mem & misaligned) & ~timeout_hit;
            out_MemToReg   <= m_mem_to_reg;
            out_RegDataSrc <= m_reg_data_src;
            out_PCSrc      <= m_pc_src;
            out_RegDest    <= m_reg_dest;
            out_alu_result <= m_alu_result;
            out_mem_data   <= (ack_ok & m_mem_read) ? load_data : 32'h0;
            out_misaligned <= is_mem & misaligned;
            out_bus_error  <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (TIMEOUT=4): ALU pass-through, loads, stores, misalignment,
// timeout, back-to-back accesses and reset in the middle of an access.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_MemWrite, in_MemRead, in_RegWrite, in_MemToReg, in_RegDataSrc, in_PCSrc;
    logic [4:0]  in_RegDest;
    logic [31:0] alu_result, rs2_value;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        out_RegWrite, out_MemToReg, out_RegDataSrc, out_PCSrc;
    logic [4:0]  out_RegDest;
    logic [31:0] out_alu_result, out_mem_data;
    logic        out_misaligned, out_bus_error, stall;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;

    int vectors = 0;
    int miscompares = 0;

    memory_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_RegWrite(in_RegWrite),
        .in_MemToReg(in_MemToReg), .in_RegDataSrc(in_RegDataSrc), .in_PCSrc(in_PCSrc),
        .in_RegDest(in_RegDest), .alu_result(alu_result), .rs2_value(rs2_value),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .out_RegWrite(out_RegWrite), .out_MemToReg(out_MemToReg),
        .out_RegDataSrc(out_RegDataSrc), .out_PCSrc(out_PCSrc), .out_RegDest(out_RegDest),
        .out_alu_result(out_alu_result), .out_mem_data(out_mem_data),
        .out_misaligned(out_misaligned), .out_bus_error(out_bus_error), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mw, input logic mr, input logic rw, input logic mtr,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [1:0] sz, input logic uns);
        in_MemWrite   = mw;
        in_MemRead    = mr;
        in_RegWrite   = rw;
        in_MemToReg   = mtr;
        in_RegDataSrc = 1'b0;
        in_PCSrc      = 1'b0;
        in_RegDest    = rd;
        alu_result    = addr;
        rs2_value     = rs2;
        mem_size      = sz;
        mem_unsigned  = uns;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        bubble();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 || dmem_wstrb !== 4'h0 || dmem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_port: stall=%b req=%b we=%b wstrb=%h want all 0",
                     stall, dmem_req, dmem_we, dmem_wstrb);
        end
        vectors++;
        if (out_RegWrite !== 1'b0 || out_alu_result !== 32'h0 || out_mem_data !== 32'h0 ||
            out_misaligned !== 1'b0 || out_bus_error !== 1'b0 || out_RegDest !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_w: rw=%b alu=%h md=%h mis=%b be=%b rd=%0d want all 0",
                     out_RegWrite, out_alu_result, out_mem_data, out_misaligned,
                     out_bus_error, out_RegDest);
        end
    endtask

    task automatic test_alu();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 2'b10, 1'b0);
        in_PCSrc = 1'b1;
        step();
        vectors++;
        if (stall !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_noreq: stall=%b req=%b want 0 0", stall, dmem_req);
        end
        bubble();
        step();
        vectors++;
        if (out_RegWrite !== 1'b1 || out_RegDest !== 5'd5 || out_alu_result !== 32'h1234 ||
            out_PCSrc !== 1'b1 || out_mem_data !== 32'h0) begin
            miscompares++;
            $display("FAIL alu_w: rw=%b rd=%0d alu=%h pc=%b md=%h want 1 5 00001234 1 0",
                     out_RegWrite, out_RegDest, out_alu_result, out_PCSrc, out_mem_data);
        end
        step();
        vectors++;
        if (out_RegWrite !== 1'b0 || out_alu_result !== 32'h0) begin
            miscompares++;
            $display("FAIL alu_bubble: rw=%b alu=%h want 0 0", out_RegWrite, out_alu_result);
        end
    endtask

    // Zero-wait loads with byte/half lane selection and both extensions
    task automatic test_loads();
        logic [31:0] addrs [4] = '{32'h103, 32'h101, 32'h102, 32'h100};
        logic [31:0] rdata [4] = '{32'h80FF_FF00, 32'h0000_8000, 32'h8001_0000, 32'hCAFE_F00D};
        logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b11};
        logic        unsg  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp   [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'hCAFE_F00D};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, addrs[i], 32'h0, sizes[i], unsg[i]);
            step();
            dmem_rdata = rdata[i];
            dmem_ack   = 1'b1;
            #1;
            vectors++;
            if (dmem_req !== 1'b1 || stall !== 1'b0 || dmem_we !== 1'b0 ||
                dmem_wstrb !== 4'h0 || dmem_addr !== {addrs[i][31:2], 2'b00}) begin
                miscompares++;
                $display("FAIL load%0d_port: req=%b stall=%b we=%b wstrb=%h addr=%h", i,
                         dmem_req, stall, dmem_we, dmem_wstrb, dmem_addr);
            end
            bubble();
            step();
            dmem_ack = 1'b0;
            vectors++;
            if (out_mem_data !== exp[i] || out_RegWrite !== 1'b1) begin
                miscompares++;
                $display("FAIL load%0d_data: got %h rw=%b want %h rw=1", i, out_mem_data,
                         out_RegWrite, exp[i]);
            end
        end
    endtask

    task automatic test_store_half_wait();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h102, 32'h0000_ABCD, 2'b01, 1'b0);
        step();
        // Next instruction waits at the inputs until the ack edge
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h77, 32'h0, 2'b10, 1'b0);
        #1;
        vectors++;
        if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || dmem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_lanes: wstrb=%b wdata=%h we=%b want 1100 abcdabcd 1",
                     dmem_wstrb, dmem_wdata, dmem_we);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (stall !== 1'b1 || dmem_req !== 1'b1) begin
                miscompares++;
                $display("FAIL sh_stall%0d: stall=%b req=%b want 1 1", i, stall, dmem_req);
            end
            step();
        end
        vectors++;
        if (out_alu_result !== 32'h0) begin
            miscompares++;
            $display("FAIL sh_hold_w: alu=%h want 0", out_alu_result);
        end
        dmem_ack = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0 || dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_ack: stall=%b req=%b want 0 1", stall, dmem_req);
        end
        step();
        dmem_ack = 1'b0;
        bubble();
        #1;
        vectors++;
        if (out_alu_result !== 32'h102 || out_RegWrite !== 1'b0 || out_bus_error !== 1'b0 ||
            dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL sh_done: alu=%h rw=%b be=%b req=%b want 102 0 0 0",
                     out_alu_result, out_RegWrite, out_bus_error, dmem_req);
        end
        step();
        vectors++;
        if (out_RegDest !== 5'd7 || out_alu_result !== 32'h77 || out_RegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL sh_next: rd=%0d alu=%h rw=%b want 7 77 1", out_RegDest,
                     out_alu_result, out_RegWrite);
        end
    endtask

    task automatic test_store_lanes();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h203, 32'h1234_565A, 2'b00, 1'b0);
        step();
        vectors++;
        if (dmem_wstrb !== 4'b1000 || dmem_wdata !== 32'h5A5A_5A5A) begin
            miscompares++;
            $display("FAIL sb_lanes: wstrb=%b wdata=%h want 1000 5a5a5a5a", dmem_wstrb,
                     dmem_wdata);
        end
        dmem_ack = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h204, 32'hDEAD_BEEF, 2'b10, 1'b0);
        step();
        vectors++;
        if (dmem_wstrb !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF || dmem_req !== 1'b1 ||
            stall !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_lanes: wstrb=%b wdata=%h req=%b stall=%b", dmem_wstrb,
                     dmem_wdata, dmem_req, stall);
        end
        bubble();
        step();
        dmem_ack = 1'b0;
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h101, 32'h0, 2'b10, 1'b0);
        step();
        vectors++;
        if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_noreq: req=%b stall=%b want 0 0", dmem_req, stall);
        end
        bubble();
        step();
        vectors++;
        if (out_misaligned !== 1'b1 || out_RegWrite !== 1'b0 || out_mem_data !== 32'h0) begin
            miscompares++;
            $display("FAIL mis_w: mis=%b rw=%b md=%h want 1 0 0", out_misaligned,
                     out_RegWrite, out_mem_data);
        end
    endtask

    task automatic test_timeout();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h200, 32'h0, 2'b10, 1'b0);
        step();
        bubble();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dmem_req !== 1'b1 || stall !== 1'b1) begin
                miscompares++;
                $display("FAIL to_wait%0d: req=%b stall=%b want 1 1", i, dmem_req, stall);
            end
            step();
        end
        vectors++;
        if (dmem_req !== 1'b1 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL to_last: req=%b stall=%b want 1 0", dmem_req, stall);
        end
        step();
        vectors++;
        if (out_bus_error !== 1'b1 || out_RegWrite !== 1'b0 || dmem_req !== 1'b0 ||
            out_alu_result !== 32'h200) begin
            miscompares++;
            $display("FAIL to_w: be=%b rw=%b req=%b alu=%h want 1 0 0 200", out_bus_error,
                     out_RegWrite, dmem_req, out_alu_result);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h300, 32'h0, 2'b10, 1'b0);
        step();
        dmem_rdata = 32'h1122_3344;
        dmem_ack   = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h302, 32'h0, 2'b01, 1'b1);
        step();
        dmem_rdata = 32'hBEEF_0000;
        #1;
        vectors++;
        if (out_mem_data !== 32'h1122_3344 || dmem_req !== 1'b1 || stall !== 1'b0 ||
            dmem_addr !== 32'h300) begin
            miscompares++;
            $display("FAIL b2b_first: md=%h req=%b stall=%b addr=%h want 11223344 1 0 300",
                     out_mem_data, dmem_req, stall, dmem_addr);
        end
        bubble();
        step();
        dmem_ack = 1'b0;
        vectors++;
        if (out_mem_data !== 32'h0000_BEEF || out_RegDest !== 5'd2) begin
            miscompares++;
            $display("FAIL b2b_second: md=%h rd=%0d want 0000beef 2", out_mem_data, out_RegDest);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h400, 32'h0, 2'b10, 1'b0);
        step();
        bubble();
        step();
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_wait: stall=%b want 1", stall);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || out_RegWrite !== 1'b0 ||
            out_alu_result !== 32'h0 || out_RegDest !== 5'd0) begin
            miscompares++;
            $display("FAIL rm_after: req=%b stall=%b rw=%b alu=%h rd=%0d want all 0",
                     dmem_req, stall, out_RegWrite, out_alu_result, out_RegDest);
        end
        dmem_rdata = 32'hFFFF_FFFF;
        dmem_ack   = 1'b1;
        step();
        dmem_ack = 1'b0;
        vectors++;
        if (out_mem_data !== 32'h0 || out_RegWrite !== 1'b0 || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_late_ack: md=%h rw=%b req=%b want 0 0 0", out_mem_data,
                     out_RegWrite, dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_store_half_wait();
        test_store_lanes();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
